psum_tile_acc: RTL

Parametrised partial-sum accumulator sitting between the PE array's psum outputs and the output write-back path. It sums LANES signed partial-sum lanes over a run-time programmable number of beats per output tile, for a programmable number of tiles, and presents each finished tile on a valid/ready output port. It generalises the fixed 2×16-lane, layer-coded accumulation stage with arbitrary lane count and widths, explicit backpressure, and optional saturation.

---
 rtl/psum_tile_acc.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/psum_tile_acc.sv
// psum_tile_acc
// Sums LANES signed partial-sum lanes over a run-time number of beats per
// output tile, for a run-time number of tiles, and presents each finished
// tile on a valid/ready output register.
//
// Build option:
//   PSUM_SAT_EN  defined   -> every addition clamps per lane to the signed
//                             DATA_WIDTH_O range, sat_flag records any clamp
//                undefined -> additions wrap modulo 2^DATA_WIDTH_O, sat_flag=0
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   start                one-cycle pulse, latches acc_len/num_tiles (idle only)
//   acc_len, num_tiles   beats per tile / tiles per run, 0 behaves as 1
//   in_valid/in_ready    psum beat handshake, in_psum lane k at [k*DATA_WIDTH_I +: DATA_WIDTH_I]
//   out_valid/out_ready  tile handshake, out_data lane k at [k*DATA_WIDTH_O +: DATA_WIDTH_O]
//   out_last             final tile of the run (qualified by out_valid)
//   busy                 run in progress
//   done                 pulse coinciding with the final tile handshake
//   sat_flag             sticky saturation indicator for the current run
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start, in_ready low
// ST_ACC   | accepting beats, emitting one tile per len beats
// ST_DRAIN | final tile loaded, waiting for it to be consumed
module psum_tile_acc #(
  parameter int LANES        = 32,
  parameter int DATA_WIDTH_I = 18,
  parameter int DATA_WIDTH_O = 22,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [CNT_WIDTH-1:0]             acc_len,
  input  logic [CNT_WIDTH-1:0]             num_tiles,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*DATA_WIDTH_I-1:0]    in_psum,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES*DATA_WIDTH_O-1:0]    out_data,
  output logic                             out_last,
  output logic                             busy,
  output logic                             done,
  output logic                             sat_flag
);

`ifdef PSUM_SAT_EN
  // One guard bit so a signed overflow is visible before clamping.
  localparam int SUM_W = DATA_WIDTH_O + 1;
`else
  // Wrapping needs only the low DATA_WIDTH_O bits of the wider sum.
  localparam int SUM_W = DATA_WIDTH_O;
`endif

  localparam int AW = LANES * DATA_WIDTH_O;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  len_m1_q, len_m1_d;
  logic [CNT_WIDTH-1:0]  beat_left_q, beat_left_d;
  logic [CNT_WIDTH-1:0]  tile_left_q, tile_left_d;
  logic [AW-1:0]         acc_q, acc_d;
  logic [AW-1:0]         out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  sat_q, sat_d;

  logic                  beat_accept;
  logic                  last_beat;
  logic                  last_tile;
  logic                  first_beat;
  logic                  out_hs;
  logic [AW-1:0]         sum_vec;
  logic [LANES-1:0]      clamp_vec;

  // Beat and tile counters run down to a terminal count of zero.
  assign last_beat   = (beat_left_q == '0);
  assign last_tile   = (tile_left_q == '0);
  assign first_beat  = (beat_left_q == len_m1_q);
  assign out_hs      = out_valid_q && out_ready;
  assign beat_accept = in_valid && in_ready;

  // Per-lane adder: the first beat of a tile starts from zero instead of
  // the stale accumulator, so accumulators never need an explicit clear.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [DATA_WIDTH_I-1:0] psum_k;
    logic signed [DATA_WIDTH_O-1:0] acc_k;
    logic signed [SUM_W-1:0]        addend_k;
    logic signed [SUM_W-1:0]        base_k;
    logic signed [SUM_W-1:0]        sum_k;

    assign psum_k   = in_psum[k*DATA_WIDTH_I +: DATA_WIDTH_I];
    assign acc_k    = acc_q[k*DATA_WIDTH_O +: DATA_WIDTH_O];
    assign addend_k = SUM_W'(psum_k);
    assign base_k   = first_beat ? '0 : SUM_W'(acc_k);
    assign sum_k    = base_k + addend_k;

`ifdef PSUM_SAT_EN
    // Guard bit disagreeing with the sign bit means the result left range.
    assign clamp_vec[k] = sum_k[SUM_W-1] ^ sum_k[SUM_W-2];
    assign sum_vec[k*DATA_WIDTH_O +: DATA_WIDTH_O] =
        !clamp_vec[k]     ? sum_k[DATA_WIDTH_O-1:0] :
        sum_k[SUM_W-1]    ? {1'b1, {(DATA_WIDTH_O-1){1'b0}}} :
                            {1'b0, {(DATA_WIDTH_O-1){1'b1}}};
`else
    assign clamp_vec[k] = 1'b0;
    assign sum_vec[k*DATA_WIDTH_O +: DATA_WIDTH_O] = sum_k;
`endif
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ACC;
      end
      ST_ACC: begin
        if (beat_accept && last_beat && last_tile) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    // The final beat of a tile needs the output register, so it waits while
    // the previous tile is still held; other beats never stall.
    in_ready = (state_q == ST_ACC) && !(last_beat && out_valid_q && !out_ready);
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DRAIN) && out_hs && out_last_q;
  end

  // Datapath and counters
  always_comb begin
    len_m1_d    = len_m1_q;
    beat_left_d = beat_left_q;
    tile_left_d = tile_left_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    sat_d       = sat_q;

    if (state_q == ST_IDLE && start) begin
      len_m1_d    = (acc_len   == '0) ? '0 : acc_len   - CNT_WIDTH'(1);
      beat_left_d = (acc_len   == '0) ? '0 : acc_len   - CNT_WIDTH'(1);
      tile_left_d = (num_tiles == '0) ? '0 : num_tiles - CNT_WIDTH'(1);
      acc_d       = '0;
      sat_d       = 1'b0;
    end

    if (out_hs) out_valid_d = 1'b0;

    if (beat_accept) begin
      sat_d = sat_q | (|clamp_vec);
      if (last_beat) begin
        // Reload takes priority over the clear from a same-cycle handshake.
        out_data_d  = sum_vec;
        out_valid_d = 1'b1;
        out_last_d  = last_tile;
        beat_left_d = len_m1_q;
        if (!last_tile) tile_left_d = tile_left_q - CNT_WIDTH'(1);
      end else begin
        acc_d       = sum_vec;
        beat_left_d = beat_left_q - CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_m1_q    <= '0;
      beat_left_q <= '0;
      tile_left_q <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      len_m1_q    <= len_m1_d;
      beat_left_q <= beat_left_d;
      tile_left_q <= tile_left_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign sat_flag  = sat_q;

endmodule
